triumph_regfile_sb: RTL and testbench

Parametrised integer register file for the Triumph core with N combinational read ports, one write-back port, a per-register scoreboard of pending writes, and optional write-to-read bypass. It replaces the fixed 32x32, two-read-port register file between the ID and EX stages. It also gives ID a reserve handshake and per-port stall flags, so hazard detection lives next to the storage.

---
 rtl/triumph_rf_pkg.sv | 14 +
 rtl/triumph_rf_read_port.sv | 38 +++
 rtl/triumph_regfile_sb.sv | 107 ++++++++++
 tb/tb_triumph_regfile_sb.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/triumph_rf_pkg.sv
// Shared constants and helpers for the Triumph integer register file.
package triumph_rf_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;
    localparam int ZERO_IDX     = 0;

    // Address width for a given register count; never below one bit.
    function automatic int calc_aw(input int num_regs);
        return (num_regs < 2) ? 1 : $clog2(num_regs);
    endfunction

endpackage

// File: rtl/triumph_rf_read_port.sv
// One combinational read port: zero-register mux, optional write-back bypass, stall flag.
// Bypass is enabled by defining TRIUMPH_RF_BYPASS_EN.
module triumph_rf_read_port
    import triumph_rf_pkg::*;
#(
    parameter int  DATA_W   = DEF_DATA_W,
    parameter int  NUM_REGS = DEF_NUM_REGS,
    parameter bit  ZERO_REG = 1'b1,
    localparam int AW       = calc_aw(NUM_REGS)
) (
    input  logic [AW-1:0]                    addr,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
    input  logic [NUM_REGS-1:0]              busy,
    input  logic                             wb_valid,
    input  logic [AW-1:0]                    wb_addr,
    input  logic [DATA_W-1:0]                wb_data,
    output logic [DATA_W-1:0]                data,
    output logic                             stall
);

`ifdef TRIUMPH_RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_IDX);

    logic is_zero;
    logic hit;

    assign is_zero = ZERO_REG && (addr == ZERO_ADDR);
    assign hit     = BYPASS && wb_valid && (wb_addr == addr) && !is_zero;

    assign data  = is_zero ? '0 : (hit ? wb_data : regs[addr]);
    assign stall = busy[addr] && !hit;

endmodule

// File: rtl/triumph_regfile_sb.sv
// Parametrised register file with N read ports, one write-back port and a pending-write scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining TRIUMPH_RF_BYPASS_EN.
module triumph_regfile_sb
    import triumph_rf_pkg::*;
#(
    parameter int  DATA_W   = DEF_DATA_W,
    parameter int  NUM_REGS = DEF_NUM_REGS,
    parameter int  NUM_RD   = DEF_NUM_RD,
    parameter bit  ZERO_REG = 1'b1,
    localparam int AW       = calc_aw(NUM_REGS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_RD*AW-1:0]      rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]  rd_data_o,
    output logic [NUM_RD-1:0]         rd_stall_o,
    input  logic                      rsv_valid_i,
    input  logic [AW-1:0]             rsv_addr_i,
    output logic                      rsv_ready_o,
    input  logic                      wb_valid_i,
    input  logic [AW-1:0]             wb_addr_i,
    input  logic [DATA_W-1:0]         wb_data_i,
    input  logic                      flush_i,
    output logic [NUM_REGS-1:0]       busy_o,
    output logic [AW:0]               busy_cnt_o
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_IDX);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0]             busy_q, busy_d;
    logic [AW:0]                     cnt_q, cnt_d;

    logic wb_we;
    logic rsv_set;
    logic wb_clr;

    assign wb_we       = wb_valid_i && !(ZERO_REG && wb_addr_i == ZERO_ADDR);
    // Ready looks only at pre-edge busy, so a same-cycle write-back never unblocks a WAW.
    assign rsv_ready_o = rsv_valid_i && !busy_q[rsv_addr_i] && !flush_i;
    assign rsv_set     = rsv_ready_o && !(ZERO_REG && rsv_addr_i == ZERO_ADDR);
    assign wb_clr      = wb_valid_i && busy_q[wb_addr_i];

    // NOTE: every storage word is reset (flops, not RAM) so reads show 0 while rst_ni is low.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q <= '0;
        end else if (wb_we) begin
            regs_q[wb_addr_i] <= wb_data_i;
        end
    end

    // NOTE: busy_d starts as a copy of busy_q so no path leaves it unassigned (no latch).
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            if (wb_valid_i) busy_d[wb_addr_i] = 1'b0;
            if (rsv_set)    busy_d[rsv_addr_i] = 1'b1;
        end
    end

    // A set and a clear in the same cycle always hit different registers, so they cancel.
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (rsv_set && !wb_clr) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (!rsv_set && wb_clr) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        triumph_rf_read_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .addr     (rd_addr_i[k*AW +: AW]),
            .regs     (regs_q),
            .busy     (busy_q),
            .wb_valid (wb_valid_i),
            .wb_addr  (wb_addr_i),
            .wb_data  (wb_data_i),
            .data     (rd_data_o[k*DATA_W +: DATA_W]),
            .stall    (rd_stall_o[k])
        );
    end

endmodule

// File: tb/tb_triumph_regfile_sb.sv
// Scoreboard bench for triumph_regfile_sb: directed scenarios plus random traffic against a reference model.
module tb_triumph_regfile_sb;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int NUM_RD   = 3;
    localparam int AW       = 5;
    localparam bit ZERO_REG = 1'b1;

    typedef logic [NUM_RD-1:0][AW-1:0] ra_t;

    typedef struct {
        logic [NUM_RD-1:0][DATA_W-1:0] data;
        logic [NUM_RD-1:0]             stall;
        logic                          ready;
        logic [NUM_REGS-1:0]           busy;
        logic [AW:0]                   cnt;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_stall;
    logic                     rsv_valid;
    logic [AW-1:0]            rsv_addr;
    logic                     rsv_ready;
    logic                     wb_valid;
    logic [AW-1:0]            wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     flush;
    logic [NUM_REGS-1:0]      busy;
    logic [AW:0]              busy_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q[$];
    exp_t mon_e;

    logic [DATA_W-1:0] m_mem  [NUM_REGS];
    bit                m_busy [NUM_REGS];

    always #5 clk = ~clk;

    triumph_regfile_sb #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .rd_stall_o  (rd_stall),
        .rsv_valid_i (rsv_valid),
        .rsv_addr_i  (rsv_addr),
        .rsv_ready_o (rsv_ready),
        .wb_valid_i  (wb_valid),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_data),
        .flush_i     (flush),
        .busy_o      (busy),
        .busy_cnt_o  (busy_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ra_t same(input logic [AW-1:0] a);
        ra_t r;
        for (int k = 0; k < NUM_RD; k++) r[k] = a;
        return r;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NUM_REGS; i++) c += m_busy[i];
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Apply one cycle of stimulus, queue the expected combinational response, then retire it in the model.
    task automatic drive(input ra_t ra, input logic rv, input logic [AW-1:0] radr,
                         input logic wv, input logic [AW-1:0] wadr, input logic [DATA_W-1:0] wdat,
                         input logic fl);
        exp_t e;
        logic rdy;
        rd_addr = ra; rsv_valid = rv; rsv_addr = radr;
        wb_valid = wv; wb_addr = wadr; wb_data = wdat; flush = fl;
        for (int k = 0; k < NUM_RD; k++) begin
            if (ZERO_REG && ra[k] == 0) begin
                e.data[k] = '0;  e.stall[k] = 1'b0;
`ifdef TRIUMPH_RF_BYPASS_EN
            end else if (wv && wadr == ra[k]) begin
                e.data[k] = wdat; e.stall[k] = 1'b0;
`endif
            end else begin
                e.data[k] = m_mem[ra[k]]; e.stall[k] = m_busy[ra[k]];
            end
        end
        rdy = rv && !m_busy[radr] && !fl;
        e.ready = rdy;
        for (int i = 0; i < NUM_REGS; i++) e.busy[i] = m_busy[i];
        e.cnt = (AW+1)'(m_count());
        exp_q.push_back(e);

        @(posedge clk); #1;
        if (wv && !(ZERO_REG && wadr == 0)) m_mem[wadr] = wdat;
        if (fl) begin
            for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 1'b0;
        end else begin
            if (wv) m_busy[wadr] = 1'b0;
            if (rdy && !(ZERO_REG && radr == 0)) m_busy[radr] = 1'b1;
        end
    endtask

    task automatic idle(input logic [AW-1:0] a);
        drive(same(a), 1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            for (int k = 0; k < NUM_RD; k++) begin
                check($sformatf("rd_data[%0d]", k), 64'(rd_data[k*DATA_W +: DATA_W]), 64'(mon_e.data[k]));
                check($sformatf("rd_stall[%0d]", k), 64'(rd_stall[k]), 64'(mon_e.stall[k]));
            end
            check("rsv_ready", 64'(rsv_ready), 64'(mon_e.ready));
            check("busy", 64'(busy), 64'(mon_e.busy));
            check("busy_cnt", 64'(busy_cnt), 64'(mon_e.cnt));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        ra_t ra;
        rd_addr = '0; rsv_valid = 0; rsv_addr = '0;
        wb_valid = 0; wb_addr = '0; wb_data = '0; flush = 0;
        model_reset();

        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_cnt", 64'(busy_cnt), 64'd0);
        check("reset_stall", 64'(rd_stall), 64'd0);
        check("reset_data", 64'(rd_data[DATA_W-1:0]), 64'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int a = 0; a < NUM_REGS; a++) idle(AW'(a));

        drive(same(5'd0), 0, 0, 1, 5'd7, 32'h0F00100A, 0);
        idle(5'd7);
        drive(same(5'd7), 0, 0, 1, 5'd0, 32'hFFFFFFFF, 0);
        idle(5'd0);

        drive(same(5'd5), 1, 5'd5, 0, 0, 0, 0);
        drive(same(5'd5), 1, 5'd5, 0, 0, 0, 0);
        drive(same(5'd5), 0, 0, 1, 5'd5, 32'hABCD0005, 0);
        idle(5'd5);

        drive(same(5'd3), 0, 0, 1, 5'd3, 32'h55, 0);
        drive(same(5'd3), 1, 5'd3, 0, 0, 0, 0);
        ra = same(5'd7); ra[0] = 5'd3;
        drive(ra, 0, 0, 1, 5'd3, 32'h11, 0);
        idle(5'd3);

        drive(same(5'd9), 1, 5'd9, 1, 5'd9, 32'h99, 0);
        idle(5'd9);

        drive(same(5'd3), 1, 5'd3, 0, 0, 0, 0);
        drive(same(5'd4), 1, 5'd4, 1, 5'd9, 32'h1234, 1);
        idle(5'd4);

        for (int a = 1; a < NUM_REGS; a++) drive(same(AW'(a)), 1, AW'(a), 0, 0, 0, 0);
        drive(same(5'd31), 1, 5'd31, 0, 0, 0, 0);
        drive(same(5'd1), 1, 5'd0, 0, 0, 0, 0);
        drive(same(5'd0), 0, 0, 0, 0, 0, 1);

        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < NUM_RD; k++) ra[k] = AW'($urandom_range(0, NUM_REGS-1));
            drive(ra, 1'($urandom), AW'($urandom_range(0, NUM_REGS-1)),
                  1'($urandom), AW'($urandom_range(0, NUM_REGS-1)), $urandom,
                  ($urandom_range(0, 39) == 0));
        end

        drive(same(5'd0), 0, 0, 0, 0, 0, 1);
        for (int a = 10; a < 15; a++) drive(same(AW'(a)), 1, AW'(a), 1, AW'(a), 32'hC0DE0000 | a, 0);
        idle(5'd10);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_busy", 64'(busy), 64'd0);
        check("midrun_reset_cnt", 64'(busy_cnt), 64'd0);
        check("midrun_reset_data", 64'(rd_data), 64'd0);
        check("midrun_reset_stall", 64'(rd_stall), 64'd0);
        model_reset();
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < NUM_RD; k++) ra[k] = AW'($urandom_range(0, NUM_REGS-1));
            drive(ra, 1'($urandom), AW'($urandom_range(0, NUM_REGS-1)),
                  1'($urandom), AW'($urandom_range(0, NUM_REGS-1)), $urandom, 1'b0);
        end

        @(negedge clk); #1;
        check("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
